// File: rtl/mem_port_arbiter_if.sv
// Bundle of the icache, dcache and external memory channels around the memory port arbiter.
// The slave view belongs to the arbiter; the master view drives the caches and the memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int TAG_BITS  = 5
);
    logic                      ic_req_valid;
    logic                      ic_req_ready;
    logic [ADDR_BITS-1:0]      ic_req_addr;
    logic [TAG_BITS-2:0]       ic_req_tag;
    logic                      ic_resp_valid;
    logic [TAG_BITS-2:0]       ic_resp_tag;

    logic                      dc_req_valid;
    logic                      dc_req_ready;
    logic                      dc_req_rw;
    logic [ADDR_BITS-1:0]      dc_req_addr;
    logic [TAG_BITS-2:0]       dc_req_tag;
    logic                      dc_req_data_valid;
    logic                      dc_req_data_ready;
    logic [DATA_BITS-1:0]      dc_req_data_bits;
    logic [DATA_BITS/8-1:0]    dc_req_data_mask;
    logic                      dc_resp_valid;
    logic [TAG_BITS-2:0]       dc_resp_tag;

    logic [DATA_BITS-1:0]      resp_data;

    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic                      mem_req_rw;
    logic [ADDR_BITS-1:0]      mem_req_addr;
    logic [TAG_BITS-1:0]       mem_req_tag;
    logic                      mem_req_data_valid;
    logic                      mem_req_data_ready;
    logic [DATA_BITS-1:0]      mem_req_data_bits;
    logic [DATA_BITS/8-1:0]    mem_req_data_mask;
    logic                      mem_resp_valid;
    logic [TAG_BITS-1:0]       mem_resp_tag;
    logic [DATA_BITS-1:0]      mem_resp_data;

    modport slave (
        input  ic_req_valid, ic_req_addr, ic_req_tag,
        output ic_req_ready, ic_resp_valid, ic_resp_tag,
        input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_tag,
        input  dc_req_data_valid, dc_req_data_bits, dc_req_data_mask,
        output dc_req_ready, dc_req_data_ready, dc_resp_valid, dc_resp_tag,
        output resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
        output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready,
        input  mem_resp_valid, mem_resp_tag, mem_resp_data
    );

    modport master (
        output ic_req_valid, ic_req_addr, ic_req_tag,
        input  ic_req_ready, ic_resp_valid, ic_resp_tag,
        output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_tag,
        output dc_req_data_valid, dc_req_data_bits, dc_req_data_mask,
        input  dc_req_ready, dc_req_data_ready, dc_resp_valid, dc_resp_tag,
        input  resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
        input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready,
        output mem_resp_valid, mem_resp_tag, mem_resp_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of the external memory port between icache (read-only) and dcache.
// The grant is held through all write-data beats; the tag MSB carries the requester ID.
module mem_port_arbiter #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int TAG_BITS  = 5,
    parameter int BEATS     = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int CNT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);
    localparam logic ID_IC = 1'b0;
    localparam logic ID_DC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WDATA = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [CNT_BITS-1:0]    beat_cnt_r;
    logic [CNT_BITS-1:0]    beat_cnt_s;
    logic                   last_grant_r;
    logic                   last_grant_s;
    logic                   grant_r;
    logic                   grant_s;

    logic                   gnt_valid_s;
    logic                   gnt_rw_s;
    logic [ADDR_BITS-1:0]   gnt_addr_s;
    logic [TAG_BITS-2:0]    gnt_tag_s;
    logic                   data_hs_s;

    // Select the request fields of whichever cache currently holds the grant
    always_comb begin
        gnt_valid_s = bus.ic_req_valid;
        gnt_rw_s    = 1'b0;
        gnt_addr_s  = bus.ic_req_addr;
        gnt_tag_s   = bus.ic_req_tag;
        if (grant_r == ID_DC) begin
            gnt_valid_s = bus.dc_req_valid;
            gnt_rw_s    = bus.dc_req_rw;
            gnt_addr_s  = bus.dc_req_addr;
            gnt_tag_s   = bus.dc_req_tag;
        end else begin
            gnt_valid_s = bus.ic_req_valid;
            gnt_rw_s    = 1'b0;
            gnt_addr_s  = bus.ic_req_addr;
            gnt_tag_s   = bus.ic_req_tag;
        end
        data_hs_s = (state_r == ST_WDATA) && bus.dc_req_data_valid && bus.mem_req_data_ready;
    end

    // State, beat counter and round-robin history registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            beat_cnt_r   <= '0;
            last_grant_r <= ID_DC;
            grant_r      <= ID_IC;
        end else begin
            state_r      <= state_s;
            beat_cnt_r   <= beat_cnt_s;
            last_grant_r <= last_grant_s;
            grant_r      <= grant_s;
        end
    end

    // Next-state: arbitrate in IDLE, wait for the handshake in REQ, count beats in WDATA
    always_comb begin
        state_s      = state_r;
        beat_cnt_s   = beat_cnt_r;
        last_grant_s = last_grant_r;
        grant_s      = grant_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.ic_req_valid && bus.dc_req_valid) begin
                    grant_s = ~last_grant_r;
                    state_s = ST_REQ;
                end else if (bus.ic_req_valid) begin
                    grant_s = ID_IC;
                    state_s = ST_REQ;
                end else if (bus.dc_req_valid) begin
                    grant_s = ID_DC;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (gnt_valid_s && bus.mem_req_ready) begin
                    last_grant_s = grant_r;
                    beat_cnt_s   = '0;
                    state_s      = (grant_r == ID_DC && gnt_rw_s) ? ST_WDATA : ST_IDLE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WDATA: begin
                if (data_hs_s) begin
                    if (beat_cnt_r == LAST_BEAT) begin
                        beat_cnt_s = '0;
                        state_s    = ST_IDLE;
                    end else begin
                        beat_cnt_s = beat_cnt_r + CNT_BITS'(1);
                        state_s    = ST_WDATA;
                    end
                end else begin
                    state_s = ST_WDATA;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                beat_cnt_s = '0;
            end
        endcase
    end

    // Outputs: request/data steering by state, response routing by tag MSB; all quiet in reset
    always_comb begin
        bus.mem_req_rw         = gnt_rw_s;
        bus.mem_req_addr       = gnt_addr_s;
        bus.mem_req_tag        = {grant_r, gnt_tag_s};
        bus.mem_req_data_bits  = bus.dc_req_data_bits;
        bus.mem_req_data_mask  = bus.dc_req_data_mask;
        bus.ic_resp_tag        = bus.mem_resp_tag[TAG_BITS-2:0];
        bus.dc_resp_tag        = bus.mem_resp_tag[TAG_BITS-2:0];
        bus.resp_data          = bus.mem_resp_data;
        bus.mem_req_valid      = 1'b0;
        bus.ic_req_ready       = 1'b0;
        bus.dc_req_ready       = 1'b0;
        bus.mem_req_data_valid = 1'b0;
        bus.dc_req_data_ready  = 1'b0;
        bus.ic_resp_valid      = 1'b0;
        bus.dc_resp_valid      = 1'b0;
        if (reset) begin
            case (state_r)
                ST_REQ: begin
                    bus.mem_req_valid = gnt_valid_s;
                    bus.ic_req_ready  = (grant_r == ID_IC) && bus.mem_req_ready;
                    bus.dc_req_ready  = (grant_r == ID_DC) && bus.mem_req_ready;
                end
                ST_WDATA: begin
                    bus.mem_req_data_valid = bus.dc_req_data_valid;
                    bus.dc_req_data_ready  = bus.mem_req_data_ready;
                end
                default: begin
                    bus.mem_req_valid = 1'b0;
                end
            endcase
            bus.ic_resp_valid = bus.mem_resp_valid && !bus.mem_resp_tag[TAG_BITS-1];
            bus.dc_resp_valid = bus.mem_resp_valid &&  bus.mem_resp_tag[TAG_BITS-1];
        end else begin
            bus.mem_req_valid = 1'b0;
            bus.ic_resp_valid = 1'b0;
            bus.dc_resp_valid = 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected requests, beats and responses are queued at
// stimulus time and popped by a negedge monitor whenever the arbiter presents them.
module tb_mem_port_arbiter;
    localparam int ADDR_BITS = 28;
    localparam int DATA_BITS = 128;
    localparam int TAG_BITS  = 5;
    localparam int BEATS     = 4;
    localparam int MASK_BITS = DATA_BITS / 8;

    typedef struct { logic rw; logic [ADDR_BITS-1:0] addr; logic [TAG_BITS-1:0] tag; } req_t;
    typedef struct { logic [DATA_BITS-1:0] bits; logic [MASK_BITS-1:0] mask; } beat_t;
    typedef struct { logic ic; logic dc; logic [TAG_BITS-2:0] tag; logic [DATA_BITS-1:0] data; } resp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .TAG_BITS(TAG_BITS)) bus ();

    mem_port_arbiter #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .TAG_BITS(TAG_BITS), .BEATS(BEATS))
        dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int checks = 0;
    int errors = 0;
    req_t  exp_req_q[$];
    beat_t exp_beat_q[$];
    beat_t drv_beat_q[$];
    resp_t exp_resp_q[$];
    int    wr_beats_left = 0;
    logic  ic_hs = 1'b0, dc_hs = 1'b0, dc_dhs = 1'b0;
    logic  model_last = 1'b1;   // last served requester: 0 = ic, 1 = dc
    bit    rand_ready = 1'b0, rand_resp = 1'b0, resp_force = 1'b0, keep_data = 1'b0;
    logic [TAG_BITS-1:0] resp_tag_f = '0;

    task automatic check(input string name, input logic [DATA_BITS-1:0] act, input logic [DATA_BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        req_t r;
        beat_t b;
        resp_t e;
        bit start_wr;
        forever begin
            @(negedge clk);
            ic_hs  = bus.ic_req_valid && bus.ic_req_ready;
            dc_hs  = bus.dc_req_valid && bus.dc_req_ready;
            dc_dhs = bus.dc_req_data_valid && bus.dc_req_data_ready;
            if (!reset) begin
                check("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
                check("rst_ic_req_ready", bus.ic_req_ready, 1'b0);
                check("rst_dc_req_ready", bus.dc_req_ready, 1'b0);
                check("rst_dc_data_ready", bus.dc_req_data_ready, 1'b0);
                check("rst_mem_data_valid", bus.mem_req_data_valid, 1'b0);
                check("rst_ic_resp_valid", bus.ic_resp_valid, 1'b0);
                check("rst_dc_resp_valid", bus.dc_resp_valid, 1'b0);
                wr_beats_left = 0;
            end else begin
                start_wr = 1'b0;
                // write-data channel is open only while beats of an accepted write remain
                check("mem_data_valid", bus.mem_req_data_valid, (wr_beats_left != 0) && bus.dc_req_data_valid);
                check("dc_data_ready", bus.dc_req_data_ready, (wr_beats_left != 0) && bus.mem_req_data_ready);
                if (bus.mem_req_data_valid && bus.mem_req_data_ready && wr_beats_left != 0 && exp_beat_q.size() > 0) begin
                    b = exp_beat_q.pop_front();
                    check("beat_bits", bus.mem_req_data_bits, b.bits);
                    check("beat_mask", bus.mem_req_data_mask, b.mask);
                    wr_beats_left--;
                end
                if (exp_req_q.size() == 0 || wr_beats_left != 0)
                    check("mem_req_valid_quiet", bus.mem_req_valid, 1'b0);
                if (bus.mem_req_valid && exp_req_q.size() > 0 && wr_beats_left == 0) begin
                    check("req_addr", bus.mem_req_addr, exp_req_q[0].addr);
                    check("req_tag", bus.mem_req_tag, exp_req_q[0].tag);
                    check("req_rw", bus.mem_req_rw, exp_req_q[0].rw);
                    check("ic_req_ready", bus.ic_req_ready, !exp_req_q[0].tag[TAG_BITS-1] && bus.mem_req_ready);
                    check("dc_req_ready", bus.dc_req_ready, exp_req_q[0].tag[TAG_BITS-1] && bus.mem_req_ready);
                    if (bus.mem_req_ready) begin
                        r = exp_req_q.pop_front();
                        start_wr = r.rw;
                    end
                end else begin
                    check("ic_req_ready_idle", bus.ic_req_ready, 1'b0);
                    check("dc_req_ready_idle", bus.dc_req_ready, 1'b0);
                end
                if (start_wr) wr_beats_left = BEATS;
                if (exp_resp_q.size() > 0) begin
                    e = exp_resp_q.pop_front();
                    check("ic_resp_valid", bus.ic_resp_valid, e.ic);
                    check("dc_resp_valid", bus.dc_resp_valid, e.dc);
                    check(e.ic ? "ic_resp_tag" : "dc_resp_tag", e.ic ? bus.ic_resp_tag : bus.dc_resp_tag, e.tag);
                    check("resp_data", bus.resp_data, e.data);
                end else begin
                    check("resp_quiet", {bus.ic_resp_valid, bus.dc_resp_valid}, 2'b00);
                end
            end
        end
    endtask

    task automatic present_beat();
        if (drv_beat_q.size() > 0) begin
            bus.dc_req_data_valid = 1'b1;
            bus.dc_req_data_bits  = drv_beat_q[0].bits;
            bus.dc_req_data_mask  = drv_beat_q[0].mask;
        end else if (!keep_data) begin
            bus.dc_req_data_valid = 1'b0;
        end
    endtask

    task automatic step();
        resp_t e;
        @(posedge clk);
        #1;
        if (ic_hs) bus.ic_req_valid = 1'b0;
        if (dc_hs) bus.dc_req_valid = 1'b0;
        if (dc_dhs && drv_beat_q.size() > 0) void'(drv_beat_q.pop_front());
        present_beat();
        if (rand_ready) begin
            bus.mem_req_ready      = ($urandom_range(0, 3) != 0);
            bus.mem_req_data_ready = $urandom_range(0, 1) == 1;
        end
        bus.mem_resp_valid = 1'b0;
        if (reset && (resp_force || (rand_resp && $urandom_range(0, 2) == 0))) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_tag   = resp_force ? resp_tag_f : TAG_BITS'($urandom);
            bus.mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
            e.ic   = !bus.mem_resp_tag[TAG_BITS-1];
            e.dc   = bus.mem_resp_tag[TAG_BITS-1];
            e.tag  = bus.mem_resp_tag[TAG_BITS-2:0];
            e.data = bus.mem_resp_data;
            exp_resp_q.push_back(e);
        end
    endtask

    // Round robin at the transaction level: on a tie the requester not served last goes first.
    task automatic issue(input bit do_ic, input bit do_dc, input bit dc_rw, input bit full_mask,
                         input logic [ADDR_BITS-1:0] ic_addr, input logic [TAG_BITS-2:0] ic_tag,
                         input logic [ADDR_BITS-1:0] dc_addr, input logic [TAG_BITS-2:0] dc_tag);
        req_t ri, rd;
        beat_t b;
        ri.rw = 1'b0;  ri.addr = ic_addr; ri.tag = {1'b0, ic_tag};
        rd.rw = dc_rw; rd.addr = dc_addr; rd.tag = {1'b1, dc_tag};
        if (do_ic && do_dc) begin
            if (model_last) begin
                exp_req_q.push_back(ri); exp_req_q.push_back(rd); model_last = 1'b1;
            end else begin
                exp_req_q.push_back(rd); exp_req_q.push_back(ri); model_last = 1'b0;
            end
        end else if (do_ic) begin
            exp_req_q.push_back(ri); model_last = 1'b0;
        end else if (do_dc) begin
            exp_req_q.push_back(rd); model_last = 1'b1;
        end
        if (do_ic) begin
            bus.ic_req_valid = 1'b1; bus.ic_req_addr = ic_addr; bus.ic_req_tag = ic_tag;
        end
        if (do_dc) begin
            bus.dc_req_valid = 1'b1; bus.dc_req_rw = dc_rw; bus.dc_req_addr = dc_addr; bus.dc_req_tag = dc_tag;
            if (dc_rw) begin
                for (int i = 0; i < BEATS; i++) begin
                    b.bits = {$urandom, $urandom, $urandom, $urandom};
                    b.mask = full_mask ? {MASK_BITS{1'b1}} : MASK_BITS'($urandom);
                    exp_beat_q.push_back(b);
                    drv_beat_q.push_back(b);
                end
            end
        end
        present_beat();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.ic_req_valid || bus.dc_req_valid || bus.dc_req_data_valid || wr_beats_left != 0 ||
                exp_req_q.size() != 0) && n < 300) begin
            step();
            n++;
        end
        check("idle_within_budget", n < 300, 1'b1);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        bus.ic_req_valid = 1'b0;
        bus.dc_req_valid = 1'b0;
        drv_beat_q.delete();
        exp_beat_q.delete();
        exp_req_q.delete();
        repeat (cycles) step();
        reset = 1'b1;
        model_last = 1'b1;
    endtask

    task automatic stimulus();
        int n;
        bus.ic_req_valid = 1'b0; bus.ic_req_addr = '0; bus.ic_req_tag = '0;
        bus.dc_req_valid = 1'b0; bus.dc_req_rw = 1'b0; bus.dc_req_addr = '0; bus.dc_req_tag = '0;
        bus.dc_req_data_valid = 1'b0; bus.dc_req_data_bits = '0; bus.dc_req_data_mask = '0;
        bus.mem_req_ready = 1'b0; bus.mem_req_data_ready = 1'b0;
        bus.mem_resp_valid = 1'b0; bus.mem_resp_tag = '0; bus.mem_resp_data = '0;
        do_reset(3);

        // IC read: one-cycle latency, tag prefix, ready mirroring, response routing
        issue(1'b1, 1'b0, 1'b0, 1'b0, 28'h100, 4'h3, 28'h0, 4'h0);
        @(negedge clk);
        check("ic_lat_idle", bus.mem_req_valid, 1'b0);
        step();
        @(negedge clk);
        check("ic_lat_n1", bus.mem_req_valid, 1'b1);
        check("ic_tag_03", bus.mem_req_tag, 5'h03);
        check("ic_ready_low", bus.ic_req_ready, 1'b0);
        step();
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        check("ic_ready_mirror", bus.ic_req_ready, 1'b1);
        step();
        resp_tag_f = 5'h03;
        resp_force = 1'b1;
        step();
        resp_force = 1'b0;
        @(negedge clk);
        check("ic_resp_03", {bus.ic_resp_valid, bus.dc_resp_valid, bus.ic_resp_tag}, {1'b1, 1'b0, 4'h3});
        wait_idle();

        // simultaneous reads after reset: IC first, then strict alternation
        do_reset(2);
        rand_ready = 1'b1;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 28'h200, 4'h1, 28'h300, 4'h2);
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 1'b1, 1'($urandom), 1'b0, ADDR_BITS'($urandom), 4'($urandom),
                  ADDR_BITS'($urandom), 4'($urandom));
            wait_idle();
        end

        // DC write with full mask, IC stalled during WDATA, dc-tagged responses throughout
        resp_tag_f = 5'h12;
        resp_force = 1'b1;
        issue(1'b0, 1'b1, 1'b1, 1'b1, 28'h0, 4'h0, 28'h4440, 4'h7);
        n = 0;
        while (wr_beats_left == 0 && n < 100) begin step(); n++; end
        check("wdata_reached", n < 100, 1'b1);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 28'h5550, 4'h9, 28'h0, 4'h0);
        wait_idle();
        resp_force = 1'b0;
        step();

        // reset after two beats of a write, then a fresh write must send four beats
        issue(1'b0, 1'b1, 1'b1, 1'b1, 28'h0, 4'h0, 28'h6660, 4'h5);
        n = 0;
        while (wr_beats_left != BEATS - 2 && n < 200) begin step(); n++; end
        check("two_beats_done", n < 200, 1'b1);
        keep_data = 1'b1;
        do_reset(1);
        bus.dc_req_data_valid = 1'b1;
        step();
        @(negedge clk);
        check("post_rst_data_ready", bus.dc_req_data_ready, 1'b0);
        check("post_rst_mem_valid", bus.mem_req_valid, 1'b0);
        keep_data = 1'b0;
        bus.dc_req_data_valid = 1'b0;
        issue(1'b0, 1'b1, 1'b1, 1'b1, 28'h0, 4'h0, 28'h7770, 4'h6);
        wait_idle();

        // randomized traffic with random backpressure and responses
        rand_resp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            issue(kind != 1, kind != 0, 1'($urandom), 1'b0, ADDR_BITS'($urandom), 4'($urandom),
                  ADDR_BITS'($urandom), 4'($urandom));
            wait_idle();
        end
        rand_resp = 1'b0;
        repeat (3) step();
        check("beats_drained", exp_beat_q.size(), 0);
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
